// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and FSM state encoding for uart_char_tx
package uart_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t REQ   = 3'd1;
  localparam state_t WAIT  = 3'd2;
  localparam state_t START = 3'd3;
  localparam state_t DATA  = 3'd4;
  localparam state_t STOP  = 3'd5;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-time counter; ports clk, rst, clr (hold at 0), tick (pulse every CLKS_PER_BIT cycles after clr)
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  logic [BW-1:0] cnt;
  assign tick = cnt == BW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else cnt <= tick ? '0 : cnt + BW'(1);
  end
endmodule

// File: rtl/uart_char_tx.sv
// uart_char_tx: requests chars from a generator and sends them 8N1 LSB first; ports clk, rst, src_done, char_in[7:0] in; char_req, tx, busy out
module uart_char_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int CHAR_LAT     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       src_done,
  input  logic [7:0] char_in,
  output logic       char_req,
  output logic       tx,
  output logic       busy
);
  localparam int LW = CHAR_LAT > 1 ? $clog2(CHAR_LAT) : 1;
  state_t state;
  logic [LW-1:0] lat;
  logic [2:0] idx;
  logic [7:0] shift;
  logic tick;
  logic clr;
  // Baud counter only runs while a frame is on the wire, so every START begins at count 0
  assign clr = (state == IDLE) || (state == REQ) || (state == WAIT);
  assign char_req = state == REQ;
  assign busy = (state != IDLE) && !(state == STOP && tick);
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );
  // tx is updated on the same edge as the state change so the line level lines up with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx    <= UART_IDLE_LVL;
      lat   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: if (!src_done) state <= REQ;
        REQ: begin
          state <= WAIT;
          lat   <= '0;
        end
        WAIT: begin
          if (lat == LW'(CHAR_LAT - 1)) begin
            shift <= char_in;
            state <= START;
            tx    <= UART_START_LVL;
          end else lat <= lat + LW'(1);
        end
        START: begin
          if (tick) begin
            state <= DATA;
            idx   <= '0;
            tx    <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == 3'(UART_DATA_BITS - 1)) begin
              state <= STOP;
              tx    <= UART_IDLE_LVL;
            end else begin
              idx   <= idx + 3'd1;
              shift <= {1'b0, shift[7:1]};
              tx    <= shift[1];
            end
          end
        end
        STOP: if (tick) state <= src_done ? IDLE : REQ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_char_tx.sv
// tb_uart_char_tx: directed and random frames checked cycle by cycle against the 8N1 timing formula
module tb_uart_char_tx;
  localparam int CPB = 4;
  localparam int LAT = 2;
  localparam int PERIOD = 1 + LAT + 10 * CPB;
  logic clk = 0;
  logic rst = 1;
  logic src_done = 1;
  logic [7:0] char_in = 8'h00;
  logic char_req, tx, busy;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_req = 0;
  logic [7:0] gen_q[$];
  logic [7:0] rnd[$];

  uart_char_tx #(.CLKS_PER_BIT(CPB), .CHAR_LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .src_done(src_done),
    .char_in (char_in),
    .char_req(char_req),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Generator model: delivers the next char one cycle after it sees a request
  always @(negedge clk) begin
    if (char_req && gen_q.size() > 0) begin
      @(posedge clk);
      #1 char_in = gen_q.pop_front();
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles after the request pulse of a frame carrying b
  function automatic logic exp_tx(input int k, input logic [7:0] b);
    if (k < 1 + LAT) return 1'b1;
    if (k < 1 + LAT + CPB) return 1'b0;
    if (k < 1 + LAT + 9 * CPB) return b[(k - 1 - LAT - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (char_req) ok = 1;
    end
    if (!ok) chk("req_timeout", 0, 1);
  endtask

  task automatic check_frame(input logic [7:0] b, input int done_k, input int abort_k, input bit b2b);
    bit ok;
    wait_req(ok);
    if (b2b) chk("req_period", cyc - last_req, PERIOD);
    last_req = cyc;
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) @(negedge clk);
      if (k == done_k) src_done = 1;
      if (k == abort_k) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        return;
      end
      chk($sformatf("tx[%02h:%0d]", b, k), tx, exp_tx(k, b));
      chk($sformatf("busy[%02h:%0d]", b, k), busy, k != PERIOD - 1);
      chk($sformatf("req[%02h:%0d]", b, k), char_req, k == 0);
    end
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_req", char_req, 0);
      chk("idle_busy", busy, 0);
      chk("idle_tx", tx, 1);
    end
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
    end
    rst = 0;
    check_idle(50);
    gen_q = '{8'h41, 8'h2D, 8'h7C, 8'h0A, 8'h0D, 8'h55};
    src_done = 0;
    check_frame(8'h41, -1, -1, 0);
    check_frame(8'h2D, -1, -1, 1);
    check_frame(8'h7C, -1, -1, 1);
    check_frame(8'h0A, -1, -1, 1);
    check_frame(8'h0D, -1, -1, 1);
    check_frame(8'h55, 1 + LAT + 4 * CPB + 1, -1, 1);
    check_idle(50);
    for (int i = 0; i < 8; i++) rnd.push_back(8'($urandom));
    gen_q = '{8'hC3, 8'h96, 8'h00, 8'hFF};
    foreach (rnd[i]) gen_q.push_back(rnd[i]);
    src_done = 0;
    check_frame(8'hC3, -1, 1 + LAT + 6 * CPB + 1, 0);
    check_frame(8'h96, -1, -1, 0);
    check_frame(8'h00, -1, -1, 1);
    check_frame(8'hFF, -1, -1, 1);
    foreach (rnd[i]) check_frame(rnd[i], i == 7 ? PERIOD - 3 : -1, -1, 1);
    check_idle(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
